i2c_tof_responder: RTL and testbench
====================================

Name: i2c_tof_responder

Overview:
- Synthesizable I2C target that answers the ToF sensor I2C master the way one VL53L5CX-style sensor would: 7-bit device address, 16-bit register index, byte data, index auto-increment.
- Sits on one ToF_SCL/ToF_SDA pair in simulation and in loop-back builds, so the master FSMs (init, firmware download, ranging readout) can be checked without real sensors.
- Holds a small internal register memory and reports every accepted write on a strobe port.

Parameters:
- DEV_ADDR, 7'h29, 7-bit I2C target address the block responds to.
- MEM_AW, 8, memory address width; memory depth is 2**MEM_AW bytes, indexed by index[MEM_AW-1:0].

Ports:
- clk  in  1  system clock; must be at least 16x the SCL frequency.
- rst_n  in  1  synchronous, active-low reset.
- scl_i  in  1  SCL line level, asynchronous to clk.
- sda_i  in  1  SDA line level, asynchronous to clk.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- wr_strobe  out  1  one-cycle pulse per accepted write data byte.
- wr_addr  out  16  register index of the byte being strobed.
- wr_data  out  8  data byte being strobed.
- busy  out  1  1 from an address-matched START until STOP or NACK release.

Behaviour:
- Synchronization: scl_i and sda_i each pass a 2-FF synchronizer; a third flop provides edge detection. All decisions use the synchronized values.
- Bus conditions:
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - Both are detected from any state.
- Sampling and driving:
  - Data is sampled on the SCL rising edge.
  - sda_oe changes only on the clk cycle after an SCL falling edge is detected, so SDA is stable while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, IDX_HI, IDX_HI_ACK, IDX_LO, IDX_LO_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE: wait for START, then go to ADDR with the bit counter cleared.
- ADDR: shift in 8 bits, MSB first.
  - On a match with DEV_ADDR: go to ADDR_ACK and drive sda_oe=1 for the 9th clock.
  - On a mismatch: go to IDLE, keep sda_oe=0 and ignore the bus until the next START.
- ADDR_ACK, R/W=0: go to IDX_HI.
- ADDR_ACK, R/W=1:
  - Load mem[index] into the shift register.
  - Go to RDATA and drive the MSB on the SCL falling edge that ends the ACK clock.
- IDX_HI and IDX_LO:
  - Shift in index[15:8] and then index[7:0].
  - ACK each byte (IDX_HI_ACK, IDX_LO_ACK), then go to WDATA.
- WDATA: after the 8th bit is sampled:
  - Write mem[index]=byte.
  - Pulse wr_strobe for one cycle, with wr_addr=index and wr_data=byte valid in that same cycle.
  - ACK (WDATA_ACK), increment index, return to WDATA.
- RDATA: shift mem[index] out MSB first.
  - A bit value of 1 means sda_oe=0; a bit value of 0 means sda_oe=1.
  - After the 8th bit, release SDA, increment index and go to RDATA_ACK.
- RDATA_ACK: sample the master ACK on the 9th SCL rising edge.
  - ACK (SDA=0): load the next byte and go to RDATA.
  - NACK: keep SDA released, clear busy and wait for STOP/START.
- Index register:
  - 16 bits, wraps 16'hFFFF -> 16'h0000.
  - Memory aliases on the low MEM_AW bits.
  - The index is retained across a repeated START and a STOP, so write-index-then-repeated-START-read works.
- Repeated START in any state: go to ADDR; the index is unchanged.
- STOP in any state: go to IDLE, set sda_oe=0, busy=0. A partial byte is discarded, with no strobe and no write.
- A STOP/START on the same cycle as an SCL edge takes priority over the data path.
- Reset mid-transaction: the next cycle gives state=IDLE, sda_oe=0, busy=0, wr_strobe=0.
- Reset values:
  - sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
  - index=0, bit counter=0.
  - Memory contents are not reset.

Test Plan:
- Write 3 bytes: START, 0x52, idx 0x0004, data 0xA1 0xB2 0xC3, STOP -> ACK on all 6 bytes; 3 wr_strobe pulses with (0x0004,0xA1), (0x0005,0xB2), (0x0006,0xC3); sda_oe=0 after STOP.
- Read back: START, 0x52, idx 0x0004, repeated START, 0x53, read 3 bytes (ACK, ACK, NACK), STOP -> SDA bytes 0xA1 0xB2 0xC3; SDA released after the NACK; busy=0.
- Address mismatch: START, 0x54, 0x00, STOP -> sda_oe stays 0 throughout; no wr_strobe; busy stays 0.
- Index wrap: write idx 0xFFFF, data 0x11 0x22 -> strobes (0xFFFF,0x11), (0x0000,0x22); a read at idx 0x0000 returns 0x22.
- Abort: STOP after 4 bits of a data byte -> no wr_strobe, memory unchanged, state IDLE; the next valid transaction ACKs normally.
- Reset during RDATA while driving 0 -> sda_oe=0 the cycle after rst_n=0; no ACK to a transaction until the next START after reset release.

Source files
------------

// File: rtl/i2c_tof_responder.sv
// I2C target model of a single ToF sensor: 7-bit address, 16-bit register
// index with auto-increment, byte-wide register memory, write strobe port.
`timescale 1ns/1ps
module i2c_tof_responder #(
   parameter logic [6:0] DEV_ADDR = 7'h29,
   parameter int         MEM_AW   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe,
   output logic        wr_strobe,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      IDX_HI,
      IDX_HI_ACK,
      IDX_LO,
      IDX_LO_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  bitcnt_q, bitcnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] index_q, index_d;
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic        rw_q, rw_d;
   logic        wr_strobe_q, wr_strobe_d;
   logic [15:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;

   logic        scl_s1_q, scl_s2_q, scl_s3_q;
   logic        sda_s1_q, sda_s2_q, sda_s3_q;
   logic        scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]  byte_in;
   logic [7:0]  mem_rdata;
   logic        mem_we;

   logic [7:0]  mem_q [2**MEM_AW];

   // Line synchronizers plus one history flop for edge detection; left
   // unreset so they keep tracking the bus and cannot fake an edge on reset exit.
   always_ff @(posedge clk) begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_s3_q <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_s3_q <= sda_s2_q;
   end

   assign scl_rise  = scl_s2_q & ~scl_s3_q;
   assign scl_fall  = ~scl_s2_q & scl_s3_q;
   assign start_det = scl_s2_q & scl_s3_q & sda_s3_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & scl_s3_q & ~sda_s3_q & sda_s2_q;
   assign byte_in   = {shift_q[6:0], sda_s2_q};
   assign mem_rdata = mem_q[index_q[MEM_AW-1:0]];

   // Register memory write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem_q[index_q[MEM_AW-1:0]] <= byte_in;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         shift_q     <= '0;
         index_q     <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         rw_q        <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         index_q     <= index_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         rw_q        <= rw_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Next-state logic. ACK states use bitcnt as a phase counter:
   // 0 = await fall that opens the 9th clock, 1 = await 9th rise,
   // 2 = await fall that closes the 9th clock.
   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      shift_d     = shift_q;
      index_d     = index_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      rw_d        = rw_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      mem_we      = 1'b0;

      if (start_det) begin
         state_d  = ADDR;
         bitcnt_d = '0;
         sda_oe_d = 1'b0;
      end else if (stop_det) begin
         state_d  = IDLE;
         bitcnt_d = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ADDR, IDX_HI, IDX_LO, WDATA: begin
               if (scl_rise) begin
                  shift_d  = byte_in;
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd7) begin
                     bitcnt_d = '0;
                     if (state_q == ADDR) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                           state_d = ADDR_ACK;
                           rw_d    = byte_in[0];
                           busy_d  = 1'b1;
                        end else begin
                           state_d = IDLE;
                           busy_d  = 1'b0;
                        end
                     end else if (state_q == IDX_HI) begin
                        index_d[15:8] = byte_in;
                        state_d       = IDX_HI_ACK;
                     end else if (state_q == IDX_LO) begin
                        index_d[7:0] = byte_in;
                        state_d      = IDX_LO_ACK;
                     end else begin
                        mem_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = index_q;
                        wr_data_d   = byte_in;
                        index_d     = index_q + 16'd1;
                        state_d     = WDATA_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, IDX_HI_ACK, IDX_LO_ACK, WDATA_ACK: begin
               if (scl_fall && bitcnt_q == 4'd0) begin
                  sda_oe_d = 1'b1;
                  bitcnt_d = 4'd1;
               end else if (scl_rise && bitcnt_q == 4'd1) begin
                  bitcnt_d = 4'd2;
               end else if (scl_fall && bitcnt_q == 4'd2) begin
                  bitcnt_d = '0;
                  sda_oe_d = 1'b0;
                  if (state_q == ADDR_ACK) begin
                     if (rw_q) begin
                        shift_d  = mem_rdata;
                        sda_oe_d = ~mem_rdata[7];
                        state_d  = RDATA;
                     end else begin
                        state_d = IDX_HI;
                     end
                  end else if (state_q == IDX_HI_ACK) begin
                     state_d = IDX_LO;
                  end else begin
                     state_d = WDATA;
                  end
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd7) begin
                     bitcnt_d = '0;
                     index_d  = index_q + 16'd1;
                     state_d  = RDATA_ACK;
                  end
               end else if (scl_fall) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end
            end
            RDATA_ACK: begin
               if (scl_fall && bitcnt_q == 4'd0) begin
                  sda_oe_d = 1'b0;
                  bitcnt_d = 4'd1;
               end else if (scl_rise && bitcnt_q == 4'd1) begin
                  if (!sda_s2_q) begin
                     shift_d  = mem_rdata;
                     bitcnt_d = 4'd2;
                  end else begin
                     bitcnt_d = '0;
                     busy_d   = 1'b0;
                     state_d  = IDLE;
                  end
               end else if (scl_fall && bitcnt_q == 4'd2) begin
                  bitcnt_d = '0;
                  sda_oe_d = ~shift_q[7];
                  state_d  = RDATA;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_tof_responder.sv
// Directed bench for i2c_tof_responder: bit-banged I2C master on an
// open-drain SDA line, write strobes captured into a queue.
`timescale 1ns/1ps
module tb_i2c_tof_responder;

   localparam time Q = 60ns;

   logic        clk;
   logic        rst_n;
   logic        m_scl;
   logic        m_sda;
   logic        sda_line;
   logic        sda_oe;
   logic        wr_strobe;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy;

   int checks;
   int failures;
   int oe_cnt;
   int glitch_cnt;
   logic prev_oe;
   logic [23:0] stb_q[$];

   i2c_tof_responder #(.DEV_ADDR(7'h29), .MEM_AW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (m_scl),
      .sda_i     (sda_line),
      .sda_oe    (sda_oe),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   assign sda_line = m_sda & ~sda_oe;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitors: strobe capture, drive activity, and SDA changes while SCL high.
   initial prev_oe = 1'b0;
   always @(negedge clk) begin
      if (wr_strobe === 1'b1) stb_q.push_back({wr_addr, wr_data});
      if (sda_oe === 1'b1) oe_cnt++;
      if (sda_oe !== prev_oe && m_scl === 1'b1) glitch_cnt++;
      prev_oe = sda_oe;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_stb(input string tag, input logic [15:0] a, input logic [7:0] d);
      logic [23:0] e;
      if (stb_q.size() == 0) begin
         chk({tag, "_present"}, 32'd0, 32'd1);
      end else begin
         e = stb_q.pop_front();
         chk({tag, "_addr"}, {16'd0, e[23:8]}, {16'd0, a});
         chk({tag, "_data"}, {24'd0, e[7:0]}, {24'd0, d});
      end
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b0; #Q;
      m_scl = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; #Q;
      m_scl = 1'b1; #Q;
      m_sda = 1'b1; #Q;
   endtask

   task automatic wbit(input logic b);
      m_sda = b; #Q;
      m_scl = 1'b1; #Q;
      #Q;
      m_scl = 1'b0; #Q;
   endtask

   task automatic rbit(output logic b);
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      b = sda_line; #Q;
      m_scl = 1'b0; #Q;
   endtask

   // Returns the line level in the 9th clock (0 = acknowledged).
   task automatic wbyte(input logic [7:0] v, output logic ack_lvl);
      for (int i = 7; i >= 0; i--) wbit(v[i]);
      rbit(ack_lvl);
   endtask

   task automatic rbyte(input logic master_ack, output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         v[i] = b;
      end
      wbit(master_ack ? 1'b0 : 1'b1);
   endtask

   initial begin
      logic       a;
      logic [7:0] rd;
      int         oe_before;

      checks = 0; failures = 0; oe_cnt = 0; glitch_cnt = 0;
      m_scl = 1'b1; m_sda = 1'b1; rst_n = 1'b0;
      repeat (6) @(posedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      chk("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
      chk("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
      chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // Write 0xA1 0xB2 0xC3 at index 0x0004
      i2c_start();
      wbyte(8'h52, a); chk("w1_addr_ack", {31'd0, a}, 32'd0);
      chk("w1_busy", {31'd0, busy}, 32'd1);
      wbyte(8'h00, a); chk("w1_idxhi_ack", {31'd0, a}, 32'd0);
      wbyte(8'h04, a); chk("w1_idxlo_ack", {31'd0, a}, 32'd0);
      wbyte(8'hA1, a); chk("w1_d0_ack", {31'd0, a}, 32'd0);
      wbyte(8'hB2, a); chk("w1_d1_ack", {31'd0, a}, 32'd0);
      wbyte(8'hC3, a); chk("w1_d2_ack", {31'd0, a}, 32'd0);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("w1_nstb", stb_q.size(), 32'd3);
      chk_stb("w1_s0", 16'h0004, 8'hA1);
      chk_stb("w1_s1", 16'h0005, 8'hB2);
      chk_stb("w1_s2", 16'h0006, 8'hC3);
      chk("w1_oe_after_stop", {31'd0, sda_oe}, 32'd0);
      chk("w1_busy_after_stop", {31'd0, busy}, 32'd0);

      // Set index 0x0004, repeated START, read three bytes
      i2c_start();
      wbyte(8'h52, a); chk("r1_addr_ack", {31'd0, a}, 32'd0);
      wbyte(8'h00, a); chk("r1_idxhi_ack", {31'd0, a}, 32'd0);
      wbyte(8'h04, a); chk("r1_idxlo_ack", {31'd0, a}, 32'd0);
      i2c_start();
      wbyte(8'h53, a); chk("r1_raddr_ack", {31'd0, a}, 32'd0);
      rbyte(1'b1, rd); chk("r1_b0", {24'd0, rd}, 32'hA1);
      rbyte(1'b1, rd); chk("r1_b1", {24'd0, rd}, 32'hB2);
      rbyte(1'b0, rd); chk("r1_b2", {24'd0, rd}, 32'hC3);
      repeat (4) @(negedge clk);
      chk("r1_oe_after_nack", {31'd0, sda_oe}, 32'd0);
      chk("r1_busy_after_nack", {31'd0, busy}, 32'd0);
      i2c_stop();
      chk("r1_nstb", stb_q.size(), 32'd0);

      // Address mismatch
      oe_before = oe_cnt;
      i2c_start();
      wbyte(8'h54, a); chk("mm_addr_nack", {31'd0, a}, 32'd1);
      chk("mm_busy", {31'd0, busy}, 32'd0);
      wbyte(8'h00, a); chk("mm_d_nack", {31'd0, a}, 32'd1);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("mm_oe_never", oe_cnt - oe_before, 32'd0);
      chk("mm_nstb", stb_q.size(), 32'd0);
      chk("mm_busy_end", {31'd0, busy}, 32'd0);

      // Index wrap 0xFFFF -> 0x0000
      i2c_start();
      wbyte(8'h52, a); chk("wr_addr_ack", {31'd0, a}, 32'd0);
      wbyte(8'hFF, a);
      wbyte(8'hFF, a);
      wbyte(8'h11, a); chk("wr_d0_ack", {31'd0, a}, 32'd0);
      wbyte(8'h22, a); chk("wr_d1_ack", {31'd0, a}, 32'd0);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("wr_nstb", stb_q.size(), 32'd2);
      chk_stb("wr_s0", 16'hFFFF, 8'h11);
      chk_stb("wr_s1", 16'h0000, 8'h22);
      i2c_start();
      wbyte(8'h52, a);
      wbyte(8'h00, a);
      wbyte(8'h00, a);
      i2c_start();
      wbyte(8'h53, a); chk("wr_raddr_ack", {31'd0, a}, 32'd0);
      rbyte(1'b0, rd); chk("wr_rd0", {24'd0, rd}, 32'h22);
      i2c_stop();

      // Abort after 4 bits of a data byte at index 0x0005
      i2c_start();
      wbyte(8'h52, a);
      wbyte(8'h00, a);
      wbyte(8'h05, a); chk("ab_idx_ack", {31'd0, a}, 32'd0);
      wbit(1'b0); wbit(1'b1); wbit(1'b0); wbit(1'b1);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("ab_nstb", stb_q.size(), 32'd0);
      chk("ab_busy", {31'd0, busy}, 32'd0);
      i2c_start();
      wbyte(8'h52, a); chk("ab_next_ack", {31'd0, a}, 32'd0);
      wbyte(8'h00, a);
      wbyte(8'h05, a);
      i2c_start();
      wbyte(8'h53, a);
      rbyte(1'b0, rd); chk("ab_mem_kept", {24'd0, rd}, 32'hB2);
      i2c_stop();

      // Reset while the target drives a 0 in RDATA (mem[0] = 0x22)
      i2c_start();
      wbyte(8'h52, a);
      wbyte(8'h00, a);
      wbyte(8'h00, a);
      i2c_start();
      wbyte(8'h53, a); chk("rs_raddr_ack", {31'd0, a}, 32'd0);
      repeat (2) @(negedge clk);
      chk("rs_driving0", {31'd0, sda_oe}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rs_oe_cleared", {31'd0, sda_oe}, 32'd0);
      chk("rs_busy_cleared", {31'd0, busy}, 32'd0);
      chk("rs_stb_low", {31'd0, wr_strobe}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wbyte(8'h52, a); chk("rs_no_start_nack", {31'd0, a}, 32'd1);
      i2c_stop();
      i2c_start();
      wbyte(8'h52, a); chk("rs_restart_ack", {31'd0, a}, 32'd0);
      chk("rs_busy", {31'd0, busy}, 32'd1);
      i2c_stop();
      repeat (4) @(negedge clk);
      chk("rs_busy_end", {31'd0, busy}, 32'd0);

      chk("oe_while_scl_high", glitch_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
